// File: rtl/mdu_pkg.sv
// Shared op encodings, FSM states and constants for the multiply/divide unit.
package mdu_pkg;

  parameter int WIDTH = 32;
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Applies sign correction to unsigned magnitude results and maps them onto HI/LO.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic               neg_res,
  input  logic               neg_rem,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  // Divide leaves {remainder, quotient} in the accumulator; multiply leaves the product.
  always_comb begin
    prod = neg_res ? -acc : acc;
    quot = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      hi = rem;
      lo = quot;
    end else begin
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO and MTHI/MTLO write ports.
// Define MDU_FAST_MUL_EN to replace the shift-add multiply with a single-cycle multiplier.
module mdu_iter #(
  parameter int WIDTH = mdu_pkg::WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mdu_pkg::*;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               div0_q, div0_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               done_q, done_d;

  op_e                op_in;
  logic               op_is_div, op_is_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;

  always_comb begin
    op_in        = op_e'(op);
    op_is_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
    op_is_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    rs_neg       = op_is_signed & rs_data[WIDTH-1];
    rt_neg       = op_is_signed & rt_data[WIDTH-1];
    rs_mag       = rs_neg ? -rs_data : rs_data;
    rt_mag       = rt_neg ? -rt_data : rt_data;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  always_comb begin
    fast_prod = {{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag};
  end
`endif

  // One shift-add step (acc = {partial, multiplier}) and one restoring step
  // (acc = {remainder, dividend/quotient}); opnd_q holds multiplicand or divisor.
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_step, div_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, opnd_q};
    if (div_trial[WIDTH]) begin
      div_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  logic [WIDTH-1:0] fix_hi, fix_lo;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .neg_res (neg_res_q),
    .neg_rem (neg_rem_q),
    .hi      (fix_hi),
    .lo      (fix_lo)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          is_div_d  = op_is_div;
          neg_res_d = rs_neg ^ rt_neg;
          neg_rem_d = rs_neg;
          cnt_d     = '0;
          div0_d    = op_is_div && (rt_data == '0);
          if (op_is_div) begin
            opnd_d = rt_mag;
            acc_d  = {{WIDTH{1'b0}}, rs_mag};
          end else begin
            opnd_d = rs_mag;
            acc_d  = {{WIDTH{1'b0}}, rt_mag};
          end
          // Divide by zero parks |rs| as the remainder so sign fix restores raw rs.
          if (op_is_div && (rt_data == '0)) begin
            acc_d   = {rs_mag, {WIDTH{1'b0}}};
            state_d = ST_FIX;
          end else begin
            state_d = ST_RUN;
          end
`ifdef MDU_FAST_MUL_EN
          if (!op_is_div) begin
            acc_d   = fast_prod;
            state_d = ST_FIX;
          end
`endif
        end
      end
      ST_RUN: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        hi_d    = fix_hi;
        lo_d    = div0_q ? WIDTH'(DIV0_LO) : fix_lo;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases plus random ops against an arithmetic model.
module tb_mdu_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] rs_data, rt_data, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mdu_iter #(.WIDTH(W), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result straight from integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] mh, output logic [W-1:0] ml);
    longint      sa, sb, sq, sr;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    mh = '0;
    ml = '0;
    if (o[1] && b == '0) begin
      mh = a;
      ml = 32'hFFFF_FFFF;
    end else begin
      case (o)
        2'b00: begin p = 64'(sa * sb); mh = p[63:32]; ml = p[31:0]; end
        2'b01: begin p = ua * ub;      mh = p[63:32]; ml = p[31:0]; end
        2'b10: begin
          sq = sa / sb; sr = sa % sb;
          p = 64'(sq); ml = p[31:0];
          p = 64'(sr); mh = p[31:0];
        end
        default: begin
          p = ua / ub; ml = p[31:0];
          p = ua % ub; mh = p[31:0];
        end
      endcase
    end
  endfunction

  // Called at a negedge; launches an op and follows it to done.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit disturb, input bit mt_en,
                        input logic [W-1:0] mt_val, input bit b2b);
    logic [W-1:0] eh, el;
    int k, busy_n, lat_exp;
    model(o, a, b, eh, el);
    lat_exp = (o[1] && b == '0) ? 1 : 33;
`ifdef MDU_FAST_MUL_EN
    if (!o[1]) lat_exp = 1;
`endif
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    if (mt_en) begin hi_we = 1'b1; lo_we = 1'b1; wdata = mt_val; end
    k = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
        check({tag, ".done_low_first"}, 32'(done), 32'd0);
        if (mt_en) begin
          check({tag, ".mthi_same_cycle"}, hi, mt_val);
          check({tag, ".mtlo_same_cycle"}, lo, mt_val);
        end
      end
      if (disturb && k == 10) begin
        start = 1'b1; op = 2'b11; rs_data = $urandom; rt_data = '0;
        hi_we = 1'b1; wdata = 32'h0000_1234;
      end
      if (disturb && k == 11) begin start = 1'b0; hi_we = 1'b0; end
      if (busy) busy_n++;
    end while (!done && k < 60);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".latency"}, 32'(k - 1), 32'(lat_exp));
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'(lat_exp));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ".hi"}, hi, eh);
    check({tag, ".lo"}, lo, el);
    if (disturb) check({tag, ".hi_not_mthi"}, 32'(hi != 32'h0000_1234), 32'd1);
    $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h latency=%0d (%s)", o, a, b, hi, lo, k - 1, tag);
    if (!b2b) begin
      @(negedge clk);
      check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    int           sel;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.hi", hi, '0);
    check("reset.lo", lo, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // MTHI/MTLO while idle
    hi_we = 1'b1; wdata = 32'hA5A5_0001;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A_0002;
    @(negedge clk);
    lo_we = 1'b0;
    check("mthi.hi", hi, 32'hA5A5_0001);
    check("mtlo.lo", lo, 32'h5A5A_0002);
    $display("mthi/mtlo hi=%h lo=%h", hi, lo);

    run_op("mult_neg1x2",  2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, '0, 1'b0);
    run_op("multu_ffx2",   2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, '0, 1'b0);
    run_op("div_m7_2",     2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, '0, 1'b0);
    run_op("divu_by0",     2'b11, 32'h0000_0064, 32'h0000_0000, 1'b0, 1'b0, '0, 1'b0);
    run_op("div_by0_neg",  2'b10, 32'h8000_0005, 32'h0000_0000, 1'b0, 1'b0, '0, 1'b0);
    run_op("div_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
    run_op("divu_big",     2'b11, 32'hFFFF_FFFF, 32'h0000_0007, 1'b0, 1'b0, '0, 1'b0);
    run_op("mult_disturb", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, '0, 1'b0);
    run_op("start_mt",     2'b11, 32'h0001_0000, 32'h0000_0003, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    run_op("b2b_first",    2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0, 1'b0, '0, 1'b1);
    run_op("b2b_second",   2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, '0, 1'b0);

    // Reset in the middle of a divide
    start = 1'b1; op = 2'b10; rs_data = 32'h7FFF_0000; rt_data = 32'h0000_0123;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset.busy", 32'(busy), 32'd0);
    check("midreset.done", 32'(done), 32'd0);
    check("midreset.hi", hi, '0);
    check("midreset.lo", lo, '0);
    $display("mid-op reset busy=%0d done=%0d hi=%h lo=%h", busy, done, hi, lo);
    rst_n = 1'b1;
    run_op("after_reset",  2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0)      rb = '0;
      else if (sel == 1) rb = 32'($urandom_range(1, 15));
      else if (sel == 2) rb = -32'($urandom_range(1, 15));
      else               rb = $urandom;
      run_op("random", ro, ra, rb, 1'b0, 1'b0, '0, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.
- Sits directly downstream of the register file. It consumes read_data1 (rs) and read_data2 (rt), and holds results in private HI/LO registers.
- Asserts busy so the control unit can stall the PC while an operation is in flight.
- MFHI/MFLO read hi/lo combinationally. MTHI/MTLO write through dedicated enables.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  launch operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  in  WIDTH  multiplicand / dividend (register-file read_data1)
- rt_data  in  WIDTH  multiplier / divisor (register-file read_data2)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data (rs)
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle pulse when HI/LO have just been updated
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
  - Applies mid-operation too; the partial result is discarded.
- States: IDLE, RUN, FIX. done is a registered flag, high only in the cycle after FIX.
- IDLE:
  - start=1 latches op, operand magnitudes and result sign flags. Signed ops take two's-complement magnitudes; unsigned ops use raw values. Counter is set to 0.
  - Next state is RUN, or FIX directly if op is DIV/DIVU and rt_data==0.
- RUN, one step per clock, 32 clocks, counter 0..31:
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring division producing a WIDTH quotient and WIDTH remainder.
  - At counter==31 the next state is FIX.
- FIX, one clock: sign correction, then write HI/LO, set done, go to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ. HI=product[63:32], LO=product[31:0].
  - DIV: quotient is negated if the signs differ; remainder takes the dividend's sign. LO=quotient, HI=remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out naturally; no special case.
  - Divide by zero: HI=rs_data as latched, LO=0xFFFFFFFF, for both DIV and DIVU.
- Latency, with start accepted at edge E0:
  - busy=1 after E0. HI/LO updated and done=1 after E33; busy=0 after E33.
  - Divide by zero: done after E1.
- start while busy: ignored; no queueing.
- MTHI/MTLO:
  - hi_we/lo_we take effect only in IDLE; ignored while busy.
  - If start and hi_we/lo_we are high in the same IDLE cycle, the write happens and the operation launches.
- Back-to-back: start may be high in the done cycle (state is IDLE) and is accepted.
- Operand inputs are not required to stay stable after the start edge.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined: MULT/MULTU skip RUN and use a combinational WIDTH x WIDTH multiplier. The transition is IDLE->FIX, so done follows after E1. Division is unchanged.
- Undefined: multiply uses the 32-cycle shift-add path; no hardware multiplier is inferred.

Decomposition:
- Package mdu_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state enum: ST_IDLE, ST_RUN, ST_FIX.
  - constants WIDTH=32 and DIV0_LO=32'hFFFFFFFF.
- Sub-module mdu_sign_fix (combinational): takes magnitudes plus sign flags and returns the corrected HI/LO for both mul and div.
- The shift-add and restoring datapaths stay in mdu_iter.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=0x00000002 -> after E33 HI=0xFFFFFFFF, LO=0xFFFFFFFE, done one cycle; busy high for exactly 33 cycles.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU rs=0x00000064, rt=0 -> done after E1, HI=0x00000064, LO=0xFFFFFFFF.
- MULT in flight, at cycle 10 assert start with new operands plus hi_we with wdata=0x1234 -> both ignored; the original result lands and hi != 0x1234.
- DIV in flight, rst_n=0 at cycle 20 -> next cycle busy=0, done=0, hi=lo=0, state IDLE. A new start is accepted the cycle after rst_n returns high.
